// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// and decodes datapath mux selects and enables from the current state.
module multicycle_control #(
  parameter int OPCODE_W    = 6,
  parameter int ALU_OP_W    = 2,
  parameter int MEM_WAIT_EN = 1,
  parameter int ENABLE_JUMP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] instr_op,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  state_t              state_r;
  state_t              state_next_s;
  logic [OPCODE_W-1:0] op_r;
  logic                ready_s;

  // Without wait states the memory is treated as always ready.
  assign ready_s = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign state   = state_r;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Opcode capture; MEM_ADDR picks lw/sw from this copy, not the live input.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= {OPCODE_W{1'b0}};
    end else if (state_r == S_DECODE) begin
      op_r <= instr_op;
    end else begin
      op_r <= op_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = S_IDLE;
    case (state_r)
      S_IDLE:  state_next_s = S_FETCH;
      S_FETCH: begin
        if (ready_s) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (instr_op)
          OP_RTYPE: state_next_s = S_R_EXEC;
          OP_LW:    state_next_s = S_MEM_ADDR;
          OP_SW:    state_next_s = S_MEM_ADDR;
          OP_BEQ:   state_next_s = S_BRANCH;
          OP_ADDI:  state_next_s = S_ADDI_EXEC;
          OP_J: begin
            if (ENABLE_JUMP != 0) begin
              state_next_s = S_JUMP;
            end else begin
              state_next_s = S_TRAP;
            end
          end
          default:  state_next_s = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        if (op_r == OP_SW) begin
          state_next_s = S_MEM_WR;
        end else begin
          state_next_s = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (ready_s) begin
          state_next_s = S_MEM_WB;
        end else begin
          state_next_s = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        if (ready_s) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEM_WR;
        end
      end
      S_MEM_WB:    state_next_s = S_FETCH;
      S_R_EXEC:    state_next_s = S_R_WB;
      S_R_WB:      state_next_s = S_FETCH;
      S_BRANCH:    state_next_s = S_FETCH;
      S_ADDI_EXEC: state_next_s = S_ADDI_WB;
      S_ADDI_WB:   state_next_s = S_FETCH;
      S_JUMP:      state_next_s = S_FETCH;
      S_TRAP:      state_next_s = S_TRAP;
      default:     state_next_s = S_IDLE;
    endcase
  end

  // Datapath control decode; everything not named for a state stays 0.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_OP_W'(2'b00);
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready_s;
        pc_write  = ready_s;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = ready_s;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_W'(2'b10);
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_W'(2'b01);
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
      end
      default: begin
        illegal_op = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and randomized instruction streams
// checked against a per-instruction state-sequence and control-table model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mem_ready;
  logic [5:0] instr_op;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;

  logic       rst2, rdy2;
  logic [5:0] op2;
  logic       pc_write2, pc_write_cond2, i_or_d2, mem_read2, mem_write2, ir_write2;
  logic       mem_to_reg2, reg_dst2, reg_write2, alu_src_a2, instr_done2, illegal_op2;
  logic [1:0] pc_source2, alu_src_b2;
  logic [2:0] alu_op2;
  logic [3:0] state2;

  multicycle_control u_dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  multicycle_control #(.OPCODE_W(6), .ALU_OP_W(3), .MEM_WAIT_EN(0), .ENABLE_JUMP(0)) u_nowait (
    .clk(clk), .rst(rst2), .instr_op(op2), .mem_ready(rdy2),
    .pc_write(pc_write2), .pc_write_cond(pc_write_cond2), .pc_source(pc_source2),
    .i_or_d(i_or_d2), .mem_read(mem_read2), .mem_write(mem_write2), .ir_write(ir_write2),
    .mem_to_reg(mem_to_reg2), .reg_dst(reg_dst2), .reg_write(reg_write2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
    .instr_done(instr_done2), .illegal_op(illegal_op2), .state(state2)
  );

  typedef struct packed {
    logic       pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       instr_done, illegal_op;
  } ctl_t;

  typedef struct {
    int         st;
    logic       rdy;
    logic [5:0] op;
  } step_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  ctl_t  obs1, obs2;
  assign obs1 = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op};
  assign obs2 = {pc_write2, pc_write_cond2, pc_source2, i_or_d2, mem_read2, mem_write2, ir_write2,
                 mem_to_reg2, reg_dst2, reg_write2, alu_src_a2, alu_src_b2, alu_op2[1:0],
                 instr_done2, illegal_op2};

  int    checks = 0;
  int    errors = 0;
  step_t plan[$];

  // Control table: what each state must drive, given the memory-ready input.
  function automatic ctl_t exp_ctl(input int st, input logic rdy);
    ctl_t c;
    c = '0;
    case (st)
      1:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      2:  begin c.alu_src_b = 2'b11; end
      3:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      5:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
      6:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_done = rdy; end
      7:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      8:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
      9:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
                c.pc_source = 2'b01; c.instr_done = 1'b1; end
      10: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      11: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      12: begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1; end
      13: begin c.illegal_op = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk_val(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input int st, input ctl_t got, input ctl_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s st=%0d got %h exp %h", tag, st, got, exp);
    end
  endtask

  task automatic add(input int st, input logic rdy, input logic [5:0] op);
    step_t s;
    s.st = st; s.rdy = rdy; s.op = op;
    plan.push_back(s);
  endtask

  // Expected state walk for one instruction, from FETCH entry onward.
  task automatic build(input logic [5:0] op, input int wf, input int wm);
    for (int i = 0; i < wf; i++) add(1, 1'b0, 6'($urandom));
    add(1, 1'b1, 6'($urandom));
    add(2, 1'($urandom), op);
    case (op)
      OP_R:    begin add(7, 1'($urandom), 6'($urandom)); add(8, 1'($urandom), 6'($urandom)); end
      OP_LW: begin
        add(3, 1'($urandom), 6'($urandom));
        for (int i = 0; i < wm; i++) add(4, 1'b0, 6'($urandom));
        add(4, 1'b1, 6'($urandom));
        add(5, 1'($urandom), 6'($urandom));
      end
      OP_SW: begin
        add(3, 1'($urandom), 6'($urandom));
        for (int i = 0; i < wm; i++) add(6, 1'b0, 6'($urandom));
        add(6, 1'b1, 6'($urandom));
      end
      OP_BEQ:  add(9, 1'($urandom), 6'($urandom));
      OP_ADDI: begin add(10, 1'($urandom), 6'($urandom)); add(11, 1'($urandom), 6'($urandom)); end
      OP_J:    add(12, 1'($urandom), 6'($urandom));
      default: for (int i = 0; i < 12; i++) add(13, 1'($urandom), 6'($urandom));
    endcase
  endtask

  // Replays the plan against the main DUT; exp_cycles=0 means no retire expected.
  task automatic run_plan(input int exp_cycles);
    step_t s;
    int    n = 0;
    bit    seen = 1'b0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(posedge clk); #1;
      chk_val("state", int'(state), s.st);
      mem_ready = s.rdy;
      instr_op  = s.op;
      #1;
      chk_ctl("ctl", s.st, obs1, exp_ctl(s.st, s.rdy));
      n++;
      if (instr_done && !seen) begin
        seen = 1'b1;
        chk_val("cpi", n, exp_cycles);
      end
    end
    if (exp_cycles > 0 && !seen) chk_val("retire_seen", 0, 1);
  endtask

  task automatic step2(input int st, input logic r, input logic [5:0] o);
    @(posedge clk); #1;
    chk_val("nw_state", int'(state2), st);
    rdy2 = r;
    op2  = o;
    #1;
    chk_ctl("nw_ctl", st, obs2, exp_ctl(st, 1'b1));
    chk_val("nw_aluop_msb", int'(alu_op2[2]), 0);
  endtask

  initial begin
    logic [5:0] ops [6];
    int         base [6];
    int         k, wf, wm, cyc;
    ops  = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    base = '{4, 5, 4, 3, 4, 3};

    rst = 1'b1; mem_ready = 1'b0; instr_op = 6'd0;
    rst2 = 1'b1; rdy2 = 1'b0; op2 = 6'd0;
    repeat (2) begin
      @(posedge clk); #2;
      chk_val("rst_state", int'(state), 0);
      chk_ctl("rst_ctl", 0, obs1, '0);
    end
    rst = 1'b0;

    build(OP_R, 0, 0);    run_plan(4);
    build(OP_LW, 0, 2);   run_plan(7);
    build(OP_BEQ, 0, 0);  run_plan(3);
    build(OP_J, 0, 0);    run_plan(3);
    build(OP_ADDI, 3, 0); run_plan(7);

    // sw stalled in MEM_WR, then reset mid-wait
    add(1, 1'b1, 6'd0); add(2, 1'b1, OP_SW); add(3, 1'b1, OP_LW);
    add(6, 1'b0, 6'd0); add(6, 1'b0, 6'd0);
    run_plan(0);
    rst = 1'b1;
    @(posedge clk); #2;
    chk_val("rst_wr_state", int'(state), 0);
    chk_val("rst_wr_memwrite", int'(mem_write), 0);
    rst = 1'b0;

    // illegal opcode traps until reset
    build(6'b111111, 0, 0); run_plan(0);
    rst = 1'b1;
    @(posedge clk); #2;
    chk_val("trap_clear_state", int'(state), 0);
    chk_val("trap_clear_flag", int'(illegal_op), 0);
    rst = 1'b0;

    repeat (40) begin
      k  = $urandom_range(0, 5);
      wf = $urandom_range(0, 2);
      wm = $urandom_range(0, 2);
      cyc = base[k] + wf + ((ops[k] == OP_LW || ops[k] == OP_SW) ? wm : 0);
      build(ops[k], wf, wm);
      run_plan(cyc);
    end

    // No-wait, no-jump variant: mem_ready ignored, j traps
    @(posedge clk); #2;
    chk_val("nw_rst_state", int'(state2), 0);
    rst2 = 1'b0;
    step2(1, 1'b0, 6'd0);
    step2(2, 1'b0, OP_SW);
    step2(3, 1'b0, OP_LW);
    step2(6, 1'b0, 6'd0);
    step2(1, 1'b0, 6'd0);
    step2(2, 1'b0, OP_J);
    step2(13, 1'b0, 6'd0);
    step2(13, 1'b1, OP_R);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
